// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder; the serial adder reuses a single instance every cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, LSB first, WIDTH cycles per sum.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sreg;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;
    logic [WIDTH-1:0] nxt;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (s),
        .co  (co)
    );

    // The new bit enters at the MSB; on the last bit this is the full result.
    assign nxt = {s, sreg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sreg  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= co;
                    sreg  <= nxt[WIDTH-1:1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= nxt;
                        cout  <= co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf   <= carry ^ co;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an addition, sampled each rising edge.
REQ-005 The block SHALL have ports a and b, input, WIDTH, the operands, captured on an accepted start.
REQ-006 The block SHALL have port cin, input, 1, the carry-in, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1, high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking the result as valid.
REQ-009 The block SHALL have port sum, output, WIDTH, the result a+b+cin mod 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1, the carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; it SHALL be in IDLE after reset.
REQ-012 The block SHALL accept start only in IDLE or DONE; on acceptance it SHALL capture a, b and cin, clear the bit counter and the sum shift register, and enter RUN.
REQ-013 A start received in RUN SHALL be ignored, with no effect on the captured operands, the counter or the result.
REQ-014 In RUN, each cycle SHALL add one bit pair LSB-first (bit i of a and b plus the carry register) through one full-adder, shift the sum bit into the sum register from the MSB side, and store the carry-out in the carry register.
REQ-015 The carry register SHALL be loaded with cin on acceptance.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge where the counter equals WIDTH-1, the FSM SHALL move to DONE.
REQ-017 Latency: if start is accepted at edge k, then done SHALL be high exactly in the cycle after edge k+WIDTH, and busy SHALL be high in the cycles after edges k through k+WIDTH-1.
REQ-018 In DONE without start, the FSM SHALL return to IDLE on the next edge; in DONE with start, it SHALL go straight to RUN (back-to-back operation, with no IDLE cycle).
REQ-019 sum and cout SHALL hold the last completed result from DONE until the next accepted start, and SHALL be undefined-free (zero) before the first completion.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the carry reported only on cout; the pair {cout,sum} SHALL equal a+b+cin exactly.

Reset
REQ-021 When rst is high at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, cout, the carry register and the counter SHALL all be cleared to 0, regardless of state.
REQ-022 Reset SHALL take priority over start in the same cycle; an operation interrupted by reset SHALL produce no done pulse.

Configuration
REQ-023 When macro SERIAL_ADDER_OVF_EN is defined, the block SHALL add output port ovf, 1 bit, updated with sum and held with it, equal to the signed two's-complement overflow (carry into MSB XOR carry out of MSB), and cleared by reset.
REQ-024 When SERIAL_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-026 The per-bit addition SHALL be a sub-module full_adder (inputs a, b, cin; outputs s, co; s = a^b^cin, co = ab|acin|bcin), instantiated exactly once.

Verification (WIDTH=8)
REQ-027 Bench SHALL check: start with a=0x05, b=0x03, cin=0 -> done exactly 8 edges after the accepting edge, sum=0x08, cout=0, busy high for 8 cycles.
REQ-028 Bench SHALL check: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 Bench SHALL check: with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
REQ-030 Bench SHALL check: a second start with a=0x11 during RUN of 0x05+0x03 -> ignored, result 0x08, exactly one done pulse.
REQ-031 Bench SHALL check: rst asserted 4 cycles into RUN -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows.
REQ-032 Bench SHALL check: start held high in the DONE cycle with a=0x01, b=0x02 -> RUN re-entered without an IDLE cycle, and the next done gives sum=0x03.
